// File: rtl/blit_pkg.sv
// Shared types and default geometry for the sprite blitter.
// The frame-buffer address width follows from the default frame-buffer size.
package blit_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} blit_state_t;

  localparam int FB_W_DEF    = 168;
  localparam int FB_H_DEF    = 104;
  localparam int SHEET_W_DEF = 96;
  localparam int ADDR_W      = $clog2(FB_W_DEF * FB_H_DEF);

endpackage

// File: rtl/blit_scan_gen.sv
// Row-major pixel scanner: latches the blit request, walks col/row and forms
// the sheet read address plus destination address and in-bounds flag (combinational).
module blit_scan_gen
  import blit_pkg::*;
#(
  parameter int FB_W    = FB_W_DEF,
  parameter int FB_H    = FB_H_DEF,
  parameter int SHEET_W = SHEET_W_DEF,
  parameter int MAX_SPR = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load,
  input  logic              step,
  input  logic [7:0]        dst_x,
  input  logic [7:0]        dst_y,
  input  logic [6:0]        src_x,
  input  logic [6:0]        src_y,
  input  logic [4:0]        spr_w,
  input  logic [4:0]        spr_h,
  input  logic              flip_x,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              in_bounds,
  output logic              last
);

  localparam int CW = $clog2(MAX_SPR + 1);

  logic [7:0]    dx0, dy0;
  logic [6:0]    sx0, sy0;
  logic [4:0]    w, h;
  logic          flip;
  logic [CW-1:0] col, row;
  logic [CW-1:0] w_m1, h_m1, mcol;
  logic [7:0]    scol, srow;
  logic [8:0]    dx, dy;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dx0 <= '0; dy0 <= '0; sx0 <= '0; sy0 <= '0;
      w <= '0; h <= '0; flip <= 1'b0;
      col <= '0; row <= '0;
    end else if (load) begin
      dx0 <= dst_x; dy0 <= dst_y; sx0 <= src_x; sy0 <= src_y;
      w <= spr_w; h <= spr_h; flip <= flip_x;
      col <= '0; row <= '0;
    end else if (step) begin
      if (col == w_m1) begin
        col <= '0;
        row <= row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  assign w_m1 = CW'(w - 5'd1);
  assign h_m1 = CW'(h - 5'd1);
  assign last = (col == w_m1) && (row == h_m1);

  // Flip only changes which sheet column is read; the destination still walks left to right.
  assign mcol = flip ? (w_m1 - col) : col;
  assign scol = {1'b0, sx0} + 8'(mcol);
  assign srow = {1'b0, sy0} + 8'(row);
  assign rom_addr = ADDR_W'(srow) * ADDR_W'(SHEET_W) + ADDR_W'(scol);

  assign dx = {1'b0, dx0} + 9'(col);
  assign dy = {1'b0, dy0} + 9'(row);
  assign in_bounds = (dx < 9'(FB_W)) && (dy < 9'(FB_H));
  assign dst_addr  = ADDR_W'(dy) * ADDR_W'(FB_W) + ADDR_W'(dx);

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: one pixel per cycle from sheet ROM to frame buffer, writes trail reads by ROM_LAT; no backpressure.
// Optional SPRITE_BLITTER_TRANSPARENCY_EN suppresses writes of TRANSPARENT_IDX pixels.
module sprite_blitter
  import blit_pkg::*;
#(
  parameter int FB_W            = FB_W_DEF,
  parameter int FB_H            = FB_H_DEF,
  parameter int SHEET_W         = SHEET_W_DEF,
  parameter int PAL_W           = 5,
  parameter int MAX_SPR         = 16,
  parameter int ROM_LAT         = 1,
  parameter int TRANSPARENT_IDX = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [7:0]        dst_x,
  input  logic [7:0]        dst_y,
  input  logic [6:0]        src_x,
  input  logic [6:0]        src_y,
  input  logic [4:0]        spr_w,
  input  logic [4:0]        spr_h,
  input  logic              flip_x,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PAL_W-1:0]  rom_data,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [PAL_W-1:0]  fb_data,
  output logic              busy,
  output logic              done
);

  localparam int DCW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  blit_state_t       state, state_nx;
  logic              load, step, last, in_bounds;
  logic [ADDR_W-1:0] scan_rom_addr, scan_dst_addr;
  logic [DCW-1:0]    drain_cnt;
  logic              vld_q  [ROM_LAT];
  logic [ADDR_W-1:0] addr_q [ROM_LAT];

  blit_scan_gen #(
    .FB_W(FB_W), .FB_H(FB_H), .SHEET_W(SHEET_W), .MAX_SPR(MAX_SPR)
  ) u_scan (
    .CLK(CLK), .RESET(RESET), .load(load), .step(step),
    .dst_x(dst_x), .dst_y(dst_y), .src_x(src_x), .src_y(src_y),
    .spr_w(spr_w), .spr_h(spr_h), .flip_x(flip_x),
    .rom_addr(scan_rom_addr), .dst_addr(scan_dst_addr),
    .in_bounds(in_bounds), .last(last)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nx;
      drain_cnt <= (state == DRAIN) ? drain_cnt + DCW'(1) : '0;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: if (start) begin
        load     = 1'b1;
        state_nx = (spr_w != 5'd0 && spr_h != 5'd0) ? FETCH : DONE;
      end
      FETCH: if (last) state_nx = DRAIN;
      DRAIN: if (drain_cnt == DCW'(ROM_LAT - 1)) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign step = (state == FETCH);

  // Clipped pixels enter the line with valid=0 so write timing stays size-only.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        vld_q[i]  <= 1'b0;
        addr_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= step && in_bounds;
      addr_q[0] <= scan_dst_addr;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign fb_we    = vld_q[ROM_LAT-1] &&
                    !(TRANSP_EN && (rom_data == PAL_W'(TRANSPARENT_IDX)));
  assign fb_addr  = fb_we ? addr_q[ROM_LAT-1] : '0;
  assign fb_data  = fb_we ? rom_data : '0;
  assign rom_addr = step ? scan_rom_addr : '0;
  assign busy     = (state == FETCH) || (state == DRAIN);
  assign done     = (state == DONE);

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Parametrised successor to the fixed 8x8/12x12 sprite draw engine.
- Copies a rectangular sprite of run-time size (1..MAX_SPR per axis) from the sprite-sheet ROM into the frame buffer at a destination pixel.
- Adds horizontal flip, frame-buffer-edge clipping, a start/busy/done handshake and configurable ROM latency.
- Sits between the game-logic sequencer and the frame-buffer RAM write port; owns the sprite-sheet read port while busy.

Parameters:
- FB_W, 168, frame-buffer width in pixels.
- FB_H, 104, frame-buffer height in pixels.
- SHEET_W, 96, sprite-sheet width in pixels.
- PAL_W, 5, palette index width.
- MAX_SPR, 16, maximum sprite width/height.
- ROM_LAT, 1, sprite-sheet read latency in cycles (>=1).
- TRANSPARENT_IDX, 0, palette index treated as transparent (used only with the optional feature).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- start  in  1  begin blit; sampled only in IDLE.
- dst_x  in  8  destination left column.
- dst_y  in  8  destination top row.
- src_x  in  7  sheet left column.
- src_y  in  7  sheet top row.
- spr_w  in  5  sprite width, 0..MAX_SPR.
- spr_h  in  5  sprite height, 0..MAX_SPR.
- flip_x  in  1  mirror horizontally.
- rom_addr  out  15  sprite-sheet read address.
- rom_data  in  PAL_W  sprite-sheet data, valid ROM_LAT cycles after address.
- fb_we  out  1  frame-buffer write enable.
- fb_addr  out  15  frame-buffer write address.
- fb_data  out  PAL_W  palette index to write.
- busy  out  1  blit in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: every output is 0, state is IDLE, pipeline valid bits are cleared. Reset takes effect asynchronously, including mid-blit: fb_we drops immediately and no further writes occur.
- Input latch: dst/src/size/flip are latched on the accepted start. Inputs are don't-care afterwards.
- States:
  - IDLE: start=1 -> FETCH if spr_w and spr_h are both nonzero, else DONE.
  - FETCH: issues one ROM address per cycle in row-major order, column fastest. After pixel N-1 (N=w*h) -> DRAIN.
  - DRAIN: waits ROM_LAT cycles for the pipeline to empty -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- start while not in IDLE is ignored.
- busy is 1 in FETCH and DRAIN, 0 in IDLE and DONE.
- Source column: src_x+col, or src_x+(w-1-col) when flip_x=1.
- rom_addr = (src_y+row)*SHEET_W + source column. The caller guarantees the sprite lies inside the sheet; no check is made.
- Destination: dx=dst_x+col and dy=dst_y+row, computed at 9 bits with no wrap.
- Clipping: a pixel with dx>=FB_W or dy>=FB_H has fb_we=0 but still consumes its cycle, so timing is size-dependent only.
- Write pipeline: the destination address and a valid bit are delayed ROM_LAT stages to align with rom_data. fb_addr = dy*FB_W + dx; fb_data = rom_data. fb_addr/fb_data are don't-care when fb_we=0.
- Timing (start seen at cycle 0):
  - address k issued at cycle 1+k;
  - write k at cycle 1+k+ROM_LAT;
  - done at cycle N+ROM_LAT+1;
  - zero-size: done at cycle 1, no writes.
- Back-to-back: start is accepted on the cycle after done.

Optional Feature:
- Macro SPRITE_BLITTER_TRANSPARENCY_EN.
- Defined: a pixel whose rom_data equals TRANSPARENT_IDX has fb_we=0; cycle timing is unchanged.
- Undefined: every in-bounds pixel is written, and TRANSPARENT_IDX is unused.

Decomposition:
- Package blit_pkg holds:
  - blit_state_t enum {IDLE, FETCH, DRAIN, DONE};
  - default FB_W/FB_H/SHEET_W constants;
  - address-width localparam derived by $clog2.
- One sub-module, blit_scan_gen: row/col counters, flip mapping, ROM address and destination address/in-bounds generation. The top level holds the FSM and the ROM_LAT-deep delay line.

Test Plan:
- 8x8, src(0,0), dst(0,0), no flip, ROM_LAT=1 -> 64 writes, fb_addr 0..7, 168..175, ... 1176..1183; done at cycle 66; busy high cycles 1..65.
- 12x12, src(24,0), flip_x=1 -> first read address 35, second 34; 144 writes; write k carries the ROM word of mirrored column.
- 8x8 at dst(164,100) -> only cols 0..3 of rows 0..3 written (16 writes); done still at cycle 66.
- spr_w=0, spr_h=5 -> no fb_we; done at cycle 1; busy never asserted.
- RESET asserted at cycle 20 of an 8x8 blit -> fb_we/busy/done are 0 asynchronously; the next start behaves as a fresh blit.
- With the macro and TRANSPARENT_IDX=0 on a sprite containing 10 zero pixels -> 54 writes, done at cycle 66. Without the macro -> 64 writes.
